// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Types and helpers shared by the parallel-in serial-out serializer.
//   piso_state_t : serializer FSM state (IDLE, SHIFT)
//   cnt_width()  : bit-counter width for a given word length
// -----------------------------------------------------------------------------
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_t;

   // The counter must index 0..width-1. Clamp to at least one bit so that
   // a degenerate width still elaborates to a legal vector.
   function automatic int cnt_width(input int width);
      if (width <= 2) begin
         return 1;
      end
      return $clog2(width);
   endfunction

endpackage : piso_pkg

// File: rtl/piso_serializer_if.sv
// -----------------------------------------------------------------------------
// piso_serializer_if
// Load handshake plus serial line of the serializer, bundled as one port.
//   par_in     : word to transmit (producer -> serializer)
//   load_valid : producer offers par_in
//   load_ready : serializer can take a word this cycle
//   ser_out    : serial bit, 0 outside a frame
//   ser_valid  : ser_out carries a frame bit
//   ser_first  : first bit of a frame
//   ser_last   : last bit of a frame
//   done       : one-cycle pulse in the cycle after ser_last
// Modports: master = producer / line observer, slave = serializer.
// -----------------------------------------------------------------------------
interface piso_serializer_if #(
   parameter int WIDTH = 4
);

   logic [WIDTH-1:0] par_in;
   logic             load_valid;
   logic             load_ready;
   logic             ser_out;
   logic             ser_valid;
   logic             ser_first;
   logic             ser_last;
   logic             done;

   modport master (
      output par_in,
      output load_valid,
      input  load_ready,
      input  ser_out,
      input  ser_valid,
      input  ser_first,
      input  ser_last,
      input  done
   );

   modport slave (
      input  par_in,
      input  load_valid,
      output load_ready,
      output ser_out,
      output ser_valid,
      output ser_first,
      output ser_last,
      output done
   );

endinterface : piso_serializer_if

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in serial-out transmitter. A WIDTH-bit word is taken through a
// valid/ready handshake and shifted onto the line one bit per clock. A new
// word can be accepted on the last bit of the current frame, so back-to-back
// frames leave no idle gap.
//
// Parameters:
//   WIDTH     : word length in bits (>= 2)
//   MSB_FIRST : 0 = bit 0 goes first (matches the serial receiver),
//               1 = bit WIDTH-1 goes first
// Ports:
//   clk     : clock, rising edge
//   clear_n : asynchronous active-low reset; aborts any frame in flight
//   bus     : handshake + serial line (piso_serializer_if.slave)
// -----------------------------------------------------------------------------
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                    clk,
   input  logic                    clear_n,
   piso_serializer_if.slave        bus
);

   localparam int             CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   generate
      if (WIDTH < 2) begin : g_width_check
         $error("piso_serializer: WIDTH must be at least 2");
      end
   endgenerate

   piso_state_t       state_q;
   logic [WIDTH-1:0]  shreg_q;
   logic [CW-1:0]     count_q;
   logic              done_q;

   logic [WIDTH-1:0]  shreg_d;     // shifted word for the next bit
   logic              head_bit;    // bit currently at the output end
   logic              ser_valid;
   logic              at_last;
   logic              load_ready;
   logic              accept;

   // The output end is the MSB or the LSB; the register always moves toward
   // it and back-fills with zero so stale data never reaches the line.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
         assign head_bit = shreg_q[WIDTH-1];
      end else begin : g_lsb_first
         assign shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
         assign head_bit = shreg_q[0];
      end
   endgenerate

   assign ser_valid  = (state_q == SHIFT);
   assign at_last    = (count_q == LAST);
   // Ready on the last bit as well as in IDLE: this is what removes the gap
   // between consecutive frames.
   assign load_ready = (state_q == IDLE) || (ser_valid && at_last);
   assign accept     = bus.load_valid && load_ready;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= ser_valid && at_last;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  shreg_q <= bus.par_in;
                  count_q <= '0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (!at_last) begin
                  shreg_q <= shreg_d;
                  count_q <= count_q + CW'(1);
               end else if (accept) begin
                  shreg_q <= bus.par_in;
                  count_q <= '0;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.load_ready = load_ready;
   assign bus.ser_valid  = ser_valid;
   assign bus.ser_out    = ser_valid && head_bit;
   assign bus.ser_first  = ser_valid && (count_q == '0);
   assign bus.ser_last   = ser_valid && at_last;
   assign bus.done       = done_q;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Directed bench for piso_serializer. dut0 is LSB-first and feeds a small
// serial-in parallel-out receiver model; dut1 is MSB-first.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

   logic clk;
   logic clear_n;

   int n_cmp;
   int n_bad;

   piso_serializer_if #(.WIDTH(4)) bus0 ();
   piso_serializer_if #(.WIDTH(4)) bus1 ();

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut0 (
      .clk     (clk),
      .clear_n (clear_n),
      .bus     (bus0)
   );

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut1 (
      .clk     (clk),
      .clear_n (clear_n),
      .bus     (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Receiver model: first bit received ends up in rx[1], last in rx[4].
   logic [4:1] rx;
   always @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         rx <= '0;
      end else if (bus0.ser_valid) begin
         rx <= {bus0.ser_out, rx[4:2]};
      end
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear_n         = 1'b0;
      bus0.load_valid = 1'b1;
      bus0.par_in     = 4'b1111;
      bus1.load_valid = 1'b0;
      bus1.par_in     = 4'b0000;
      #1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (bus0.load_ready !== 1'b1 || bus0.ser_valid !== 1'b0 ||
             bus0.ser_out !== 1'b0 || bus0.done !== 1'b0 ||
             bus0.ser_first !== 1'b0 || bus0.ser_last !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs cyc%0d: rdy=%b val=%b out=%b done=%b first=%b last=%b, required 1 0 0 0 0 0",
                     i, bus0.load_ready, bus0.ser_valid, bus0.ser_out, bus0.done,
                     bus0.ser_first, bus0.ser_last);
         end
      end
      bus0.load_valid = 1'b0;
      clear_n         = 1'b1;
      tick();
      n_cmp++;
      if (bus0.ser_valid !== 1'b0 || bus0.load_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_no_load: val=%b rdy=%b, required 0 1", bus0.ser_valid, bus0.load_ready);
      end
      $display("test_reset: held 2 cycles with load_valid=1, released");
   endtask

   task automatic test_single_frame();
      logic [3:0] exp_bits;
      exp_bits = 4'b1011;      // index i = bit sent in cycle i (LSB first)
      bus0.par_in     = 4'b1011;
      bus0.load_valid = 1'b1;
      tick();
      bus0.load_valid = 1'b0;
      bus0.par_in     = 4'b0101;   // must not disturb the frame in flight
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (bus0.ser_valid !== 1'b1 || bus0.ser_out !== exp_bits[i] ||
             bus0.ser_first !== (i == 0) || bus0.ser_last !== (i == 3) ||
             bus0.load_ready !== (i == 3) || bus0.done !== 1'b0) begin
            n_bad++;
            $display("FAIL single_bit%0d: val=%b out=%b first=%b last=%b rdy=%b done=%b, required 1 %b %b %b %b 0",
                     i, bus0.ser_valid, bus0.ser_out, bus0.ser_first, bus0.ser_last,
                     bus0.load_ready, bus0.done, exp_bits[i], (i == 0), (i == 3), (i == 3));
         end
         tick();
      end
      n_cmp++;
      if (bus0.done !== 1'b1 || bus0.ser_valid !== 1'b0 || bus0.load_ready !== 1'b1 ||
          bus0.ser_out !== 1'b0) begin
         n_bad++;
         $display("FAIL single_done: done=%b val=%b rdy=%b out=%b, required 1 0 1 0",
                  bus0.done, bus0.ser_valid, bus0.load_ready, bus0.ser_out);
      end
      tick();
      n_cmp++;
      if (bus0.done !== 1'b0 || bus0.ser_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL single_done_clear: done=%b val=%b, required 0 0", bus0.done, bus0.ser_valid);
      end
      $display("test_single_frame: sent 4'b1011");
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_bits;
      exp_bits = 8'b0110_1011;   // cycle i carries exp_bits[i]
      bus0.par_in     = 4'b1011;
      bus0.load_valid = 1'b1;
      tick();
      bus0.par_in = 4'b0110;
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (bus0.ser_valid !== 1'b1 || bus0.ser_out !== exp_bits[i] ||
             bus0.load_ready !== (i == 3 || i == 7) || bus0.done !== (i == 4) ||
             bus0.ser_first !== (i == 0 || i == 4)) begin
            n_bad++;
            $display("FAIL b2b_cyc%0d: val=%b out=%b rdy=%b done=%b first=%b, required 1 %b %b %b %b",
                     i, bus0.ser_valid, bus0.ser_out, bus0.load_ready, bus0.done, bus0.ser_first,
                     exp_bits[i], (i == 3 || i == 7), (i == 4), (i == 0 || i == 4));
         end
         if (i == 7) bus0.load_valid = 1'b0;
         tick();
      end
      n_cmp++;
      if (bus0.done !== 1'b1 || bus0.ser_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_end: done=%b val=%b, required 1 0", bus0.done, bus0.ser_valid);
      end
      tick();
      $display("test_back_to_back: sent 4'b1011 then 4'b0110");
   endtask

   task automatic test_load_busy();
      logic [7:0] exp_bits;
      exp_bits = 8'b0000_1011;
      bus0.par_in     = 4'b1011;
      bus0.load_valid = 1'b1;
      tick();
      bus0.load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 1) begin
            bus0.load_valid = 1'b1;
            bus0.par_in     = 4'b0000;
         end
         if (i == 4) bus0.load_valid = 1'b0;
         n_cmp++;
         if (bus0.ser_valid !== 1'b1 || bus0.ser_out !== exp_bits[i] ||
             bus0.load_ready !== (i == 3 || i == 7) || bus0.ser_first !== (i == 0 || i == 4)) begin
            n_bad++;
            $display("FAIL busy_cyc%0d: val=%b out=%b rdy=%b first=%b, required 1 %b %b %b",
                     i, bus0.ser_valid, bus0.ser_out, bus0.load_ready, bus0.ser_first,
                     exp_bits[i], (i == 3 || i == 7), (i == 0 || i == 4));
         end
         tick();
      end
      n_cmp++;
      if (bus0.ser_valid !== 1'b0 || bus0.load_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL busy_end: val=%b rdy=%b, required 0 1", bus0.ser_valid, bus0.load_ready);
      end
      $display("test_load_busy: 4'b0000 offered during 4'b1011");
   endtask

   task automatic test_loopback();
      // Receiver holds 4'b0000 from the previous frame at this point.
      bus0.par_in     = 4'b1011;
      bus0.load_valid = 1'b1;
      tick();
      bus0.load_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      n_cmp++;
      if (rx !== 4'b1011) begin
         n_bad++;
         $display("FAIL loopback_rx: rx=%b, required 1011", rx);
      end
      $display("test_loopback: receiver word %b", rx);
   endtask

   task automatic test_reset_mid_frame();
      bus0.par_in     = 4'b1011;
      bus0.load_valid = 1'b1;
      tick();
      bus0.load_valid = 1'b0;
      tick();
      tick();
      // Third bit of the frame is on the line now.
      n_cmp++;
      if (bus0.ser_valid !== 1'b1 || bus0.ser_out !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_pre: val=%b out=%b, required 1 0", bus0.ser_valid, bus0.ser_out);
      end
      clear_n = 1'b0;
      #1;
      n_cmp++;
      if (bus0.ser_valid !== 1'b0 || bus0.ser_out !== 1'b0 || bus0.load_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_async: val=%b out=%b rdy=%b, required 0 0 1",
                  bus0.ser_valid, bus0.ser_out, bus0.load_ready);
      end
      tick();
      clear_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (bus0.ser_valid !== 1'b0 || bus0.ser_out !== 1'b0 || bus0.load_ready !== 1'b1 ||
             bus0.done !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_after%0d: val=%b out=%b rdy=%b done=%b, required 0 0 1 0",
                     i, bus0.ser_valid, bus0.ser_out, bus0.load_ready, bus0.done);
         end
      end
      $display("test_reset_mid_frame: aborted 4'b1011 frame");
   endtask

   task automatic test_msb_first();
      logic [3:0] exp_bits;
      exp_bits = 4'b1101;      // cycle i carries exp_bits[i]: 1,0,1,1
      bus1.par_in     = 4'b1011;
      bus1.load_valid = 1'b1;
      tick();
      bus1.load_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (bus1.ser_valid !== 1'b1 || bus1.ser_out !== exp_bits[i] ||
             bus1.ser_first !== (i == 0) || bus1.ser_last !== (i == 3)) begin
            n_bad++;
            $display("FAIL msb_bit%0d: val=%b out=%b first=%b last=%b, required 1 %b %b %b",
                     i, bus1.ser_valid, bus1.ser_out, bus1.ser_first, bus1.ser_last,
                     exp_bits[i], (i == 0), (i == 3));
         end
         tick();
      end
      n_cmp++;
      if (bus1.done !== 1'b1 || bus1.ser_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL msb_done: done=%b val=%b, required 1 0", bus1.done, bus1.ser_valid);
      end
      $display("test_msb_first: sent 4'b1011 MSB first");
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_load_busy();
      test_loopback();
      test_reset_mid_frame();
      test_msb_first();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_piso_serializer
